// File: rtl/serial_add_sub.sv
// Purpose : bit-serial WIDTH-bit adder/subtractor, one full-adder cell, LSB first.
// Latency : start accepted at edge N -> done high for one cycle after edge N+WIDTH.
// Backpr. : start is ignored while busy; start during done launches back-to-back.
//
// Optional feature macro: SERIAL_ADD_FLAGS_EN (adds overflow/zero ports + logic).
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request, accepted when not busy (IDLE or DONE)
//   sub       0: a+b, 1: a-b (captured with operands)
//   a, b      WIDTH-bit operands, captured on accepted start
//   busy      high while bits are being processed
//   done      one-cycle pulse when result/cout (and flags) become valid
//   result    sum/difference, held until the next accepted start
//   cout      final carry out (subtraction: 1 = no borrow)
//   overflow  signed overflow            (SERIAL_ADD_FLAGS_EN only)
//   zero      result == 0                (SERIAL_ADD_FLAGS_EN only)
module serial_add_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  // Derived counter width; not meant to be overridden.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADD_FLAGS_EN
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
`endif

  logic               accept;
  logic               last_bit;
  logic               fa_sum;
  logic               fa_co;
  logic [WIDTH-1:0]   result_next;

  // New work is only taken when the shifter is free.
  assign accept   = start && (state_q != S_RUN);
  assign last_bit = (cnt_q == LAST_CNT);

  // The single full-adder cell.
  assign fa_sum = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_co  = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  // Sum bits enter at the MSB and walk down, so after WIDTH shifts bit 0
  // sits at result[0].
  assign result_next = {fa_sum, result_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_FLAGS_EN
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`endif

    if (accept) begin
      // Subtraction is a + ~b + 1: invert b here, seed the carry with 1.
      a_sh_d   = a;
      b_sh_d   = sub ? ~b : b;
      carry_d  = sub;
      cnt_d    = '0;
      result_d = '0;
      cout_d   = 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
      ovf_d    = 1'b0;
      zero_d   = 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
      carry_d  = fa_co;
      cnt_d    = cnt_q + CNT_W'(1);
      result_d = result_next;
      if (last_bit) begin
        cout_d = fa_co;
`ifdef SERIAL_ADD_FLAGS_EN
        // carry_q is the carry into the MSB on this cycle, so the signed
        // overflow can be formed without a separate capture register.
        ovf_d  = carry_q ^ fa_co;
        zero_d = (result_next == '0);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SERIAL_ADD_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`endif

  // Outputs are straight decodes of registered state.
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Purpose : directed bench for serial_add_sub with a scoreboard queue.
// Latency : expects done exactly WIDTH edges after the accept edge.
// Backpr. : drives start during busy (must be ignored) and during done.
module tb_serial_add_sub;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADD_FLAGS_EN
  logic         overflow;
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  exp_t sb[$];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout)
`ifdef SERIAL_ADD_FLAGS_EN
    ,
    .overflow (overflow),
    .zero     (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain wide arithmetic.
  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   sum;
    bx    = s ? ~bb : bb;
    sum   = {1'b0, aa} + {1'b0, bx} + {{W{1'b0}}, s};
    e.res = sum[W-1:0];
    e.co  = sum[W];
    e.ov  = (aa[W-1] == bx[W-1]) && (sum[W-1] != aa[W-1]);
    e.z   = (sum[W-1:0] == '0);
    return e;
  endfunction

  // Caller is at a negedge; the accept happens on the following posedge.
  task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                        input string tag);
    a     = aa;
    b     = bb;
    sub   = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    sb.push_back(model(aa, bb, s));
    chk({tag, "_busy"}, {{W{1'b0}}, busy}, 1);
  endtask

  // Waits at negedges for done, then pops and compares. exp_lat < 0 skips the
  // latency check.
  task automatic wait_done(input int exp_lat, input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, {{W{1'b0}}, done}, 1);
      return;
    end
    if (exp_lat >= 0) chk({tag, "_latency"}, (W+1)'(n), (W+1)'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_result"}, {1'b0, result}, {1'b0, e.res});
    chk({tag, "_cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, e.co});
`ifdef SERIAL_ADD_FLAGS_EN
    chk({tag, "_ovf"},  {{W{1'b0}}, overflow}, {{W{1'b0}}, e.ov});
    chk({tag, "_zero"}, {{W{1'b0}}, zero},     {{W{1'b0}}, e.z});
`endif
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",   {{W{1'b0}}, busy}, 0);
    chk("rst_done",   {{W{1'b0}}, done}, 0);
    chk("rst_result", {1'b0, result}, 0);
    chk("rst_cout",   {{W{1'b0}}, cout}, 0);
`ifdef SERIAL_ADD_FLAGS_EN
    chk("rst_ovf",    {{W{1'b0}}, overflow}, 0);
    chk("rst_zero",   {{W{1'b0}}, zero}, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 5 + 3, also checks latency and one-cycle done
    launch(32'd5, 32'd3, 1'b0, "t1");
    wait_done(W, "t1");
    chk("t1_const", {1'b0, result}, 33'h8);
    @(negedge clk);
    chk("t1_done_pulse", {{W{1'b0}}, done}, 0);
    chk("t1_held", {1'b0, result}, 33'h8);

    // 2: wrap to zero
    launch(32'hFFFF_FFFF, 32'd1, 1'b0, "t2");
    wait_done(W, "t2");
    chk("t2_const", {cout, result}, 33'h1_0000_0000);

    // 3: 5 - 7 borrows
    @(negedge clk);
    launch(32'd5, 32'd7, 1'b1, "t3");
    wait_done(W, "t3");
    chk("t3_const", {cout, result}, 33'h0_FFFF_FFFE);

    // 4: signed overflow, add then subtract
    @(negedge clk);
    launch(32'h7FFF_FFFF, 32'd1, 1'b0, "t4a");
    wait_done(W, "t4a");
    @(negedge clk);
    launch(32'h8000_0000, 32'd1, 1'b1, "t4b");
    wait_done(W, "t4b");
    chk("t4b_const", {1'b0, result}, 33'h7FFF_FFFF);

    // 5: start while busy is ignored, then back-to-back from done
    @(negedge clk);
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, "t5a");
    repeat (9) @(negedge clk);
    a     = 32'hDEAD_BEEF;
    b     = 32'h0BAD_F00D;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_still_busy", {{W{1'b0}}, busy}, 1);
    wait_done(W - 10, "t5a");
    launch(32'hCAFE_0000, 32'h0000_BABE, 1'b1, "t5b");
    chk("t5b_no_done", {{W{1'b0}}, done}, 0);
    wait_done(W, "t5b");

    // Some extra operand patterns
    @(negedge clk);
    launch(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, "t7a");
    wait_done(W, "t7a");
    @(negedge clk);
    launch(32'h8000_0000, 32'h8000_0000, 1'b0, "t7b");
    wait_done(W, "t7b");
    @(negedge clk);
    launch(32'h0000_0000, 32'h0000_0000, 1'b1, "t7c");
    wait_done(W, "t7c");

    // 6: reset in the middle of a run aborts without a done pulse
    @(negedge clk);
    launch(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, "t6a");
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",   {{W{1'b0}}, busy}, 0);
    chk("t6_rst_done",   {{W{1'b0}}, done}, 0);
    chk("t6_rst_result", {1'b0, result}, 0);
    chk("t6_rst_cout",   {{W{1'b0}}, cout}, 0);
`ifdef SERIAL_ADD_FLAGS_EN
    chk("t6_rst_ovf",    {{W{1'b0}}, overflow}, 0);
    chk("t6_rst_zero",   {{W{1'b0}}, zero}, 0);
`endif
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("t6_no_done", (W+1)'(seen), 0);
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0, "t6b");
    wait_done(W, "t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
